// File: rtl/frame_word_streamer.sv
// Paces BRAM reads of 96-bit pixel groups and streams them as 32-bit words with a frame-end marker.
// Optional per-frame word checksum is enabled by defining PIXEL_CHECKSUM_EN.
module frame_word_streamer #(
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned GROUPS     = 76800,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        control,
    input  logic [31:0] slv1,
    input  logic [31:0] slv2,
    input  logic [31:0] slv3,
    output logic        read_enable,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        frame_done,
    output logic [31:0] checksum
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned LW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
    localparam logic [GW-1:0] GLast = GW'(GROUPS - 1);
    localparam logic [LW-1:0] LatInit = LW'(READ_LAT);

    typedef enum logic [1:0] {StIdle, StWait, StCapture, StPush} state_e;

    state_e        r_state, w_state_nxt;
    logic [LW-1:0] r_lat, w_lat_nxt;
    logic [GW-1:0] r_grp, w_grp_nxt;
    logic [1:0]    r_widx, w_widx_nxt;
    logic [95:0]   r_hold, w_hold_nxt;
    logic          r_hold_last, w_hold_last_nxt;
    logic          r_done;

    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr, r_rd;
    logic          w_empty, w_full, w_push, w_pop, w_re, w_flush;
    logic [32:0]   w_push_word, w_head;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_head  = r_mem[r_rd[AW-1:0]];
    assign w_pop   = !w_empty && m_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_nxt       = r_lat;
        w_grp_nxt       = r_grp;
        w_widx_nxt      = r_widx;
        w_hold_nxt      = r_hold;
        w_hold_last_nxt = r_hold_last;
        w_push          = 1'b0;
        w_re            = 1'b0;
        w_flush         = 1'b0;
        case (r_widx)
            2'd0:    w_push_word = {1'b0, r_hold[95:64]};
            2'd1:    w_push_word = {1'b0, r_hold[63:32]};
            default: w_push_word = {r_hold_last, r_hold[31:0]};
        endcase

        // Dropping control aborts from any state, mirroring frame_addr clearing upstream.
        if (!control) begin
            w_state_nxt     = StIdle;
            w_flush         = 1'b1;
            w_grp_nxt       = '0;
            w_hold_nxt      = '0;
            w_hold_last_nxt = 1'b0;
            w_widx_nxt      = 2'd0;
            w_lat_nxt       = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_lat_nxt   = LatInit;
                    w_state_nxt = StWait;
                end
                StWait: begin
                    if (r_lat != '0) w_lat_nxt = r_lat - LW'(1);
                    if (r_lat <= LW'(1)) w_state_nxt = StCapture;
                end
                StCapture: begin
                    w_hold_nxt      = {slv1, slv2, slv3};
                    w_hold_last_nxt = (r_grp == GLast);
                    w_grp_nxt       = (r_grp == GLast) ? '0 : r_grp + GW'(1);
                    w_lat_nxt       = LatInit;
                    w_widx_nxt      = 2'd0;
                    w_re            = 1'b1;
                    w_state_nxt     = StPush;
                end
                StPush: begin
                    if (r_lat != '0) w_lat_nxt = r_lat - LW'(1);
                    if (!w_full || w_pop) begin
                        w_push = 1'b1;
                        if (r_widx == 2'd2) begin
                            w_widx_nxt  = 2'd0;
                            w_state_nxt = (r_lat == '0) ? StCapture : StWait;
                        end else begin
                            w_widx_nxt = r_widx + 2'd1;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_lat       <= '0;
            r_grp       <= '0;
            r_widx      <= 2'd0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat       <= w_lat_nxt;
            r_grp       <= w_grp_nxt;
            r_widx      <= w_widx_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_last <= w_hold_last_nxt;
            r_done      <= control && w_pop && w_head[32];
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (w_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= w_push_word;
    end

    assign read_enable = w_re;
    assign m_valid     = !w_empty;
    assign m_data      = w_empty ? 32'h0 : w_head[31:0];
    assign m_last      = !w_empty && w_head[32];
    assign frame_done  = r_done;

`ifdef PIXEL_CHECKSUM_EN
    logic [31:0] r_acc, r_csum;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_csum <= '0;
        end else if (!control) begin
            r_acc <= '0;
        end else if (w_pop) begin
            if (w_head[32]) begin
                r_acc  <= '0;
                r_csum <= r_acc + w_head[31:0];
            end else begin
                r_acc <= r_acc + w_head[31:0];
            end
        end
    end

    assign checksum = r_csum;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_frame_word_streamer.sv
// Directed bench for frame_word_streamer with a 2-cycle-latency BRAM model (group n = {n,n+1,n+2}).
module tb_frame_word_streamer;

    logic        clk50 = 1'b0;
    logic        rst_n = 1'b1;
    logic        control = 1'b0;
    logic [31:0] slv1, slv2, slv3;
    logic        read_enable;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        frame_done;
    logic [31:0] checksum;

    int n_total = 0;
    int n_bad   = 0;

    frame_word_streamer #(
        .READ_LAT  (2),
        .GROUPS    (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .control    (control),
        .slv1       (slv1),
        .slv2       (slv2),
        .slv3       (slv3),
        .read_enable(read_enable),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_done (frame_done),
        .checksum   (checksum)
    );

    always #5 clk50 = ~clk50;

    // Upstream model: frame_addr advanced by read_enable, BRAM output two cycles behind it.
    logic [31:0] r_addr, r_d1, r_q;
    always @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 0;
            r_d1   <= 0;
            r_q    <= 0;
        end else begin
            if (!control)         r_addr <= 0;
            else if (read_enable) r_addr <= (r_addr == 3) ? 0 : r_addr + 1;
            r_d1 <= r_addr;
            r_q  <= r_d1;
        end
    end
    assign slv1 = r_q;
    assign slv2 = r_q + 1;
    assign slv3 = r_q + 2;

    logic [31:0] q_words[$];
    logic        q_last[$];
    int          re_at_last[$];
    int          n_re = 0, n_re_bad = 0, n_done = 0;
    logic        prev_re = 1'b0;

    always @(negedge clk50) begin
        if (rst_n) begin
            if (read_enable) begin
                n_re <= n_re + 1;
                if (prev_re || !control) n_re_bad <= n_re_bad + 1;
            end
            if (frame_done) n_done <= n_done + 1;
            if (m_valid && m_ready) begin
                q_words.push_back(m_data);
                q_last.push_back(m_last);
                if (m_last) re_at_last.push_back(n_re);
            end
        end
        prev_re <= read_enable;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_word(input int i);
        return ((i / 3) % 4) + (i % 3);
    endfunction

    // mode 0: m_ready always high; mode 1: high one cycle in three.
    task automatic wait_words(input string tag, input int n, input int mode, input int budget);
        int start = q_words.size();
        for (int c = 0; c < budget; c++) begin
            @(posedge clk50);
            #1;
            m_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            if (q_words.size() - start >= n) break;
        end
        check({tag, "_count"}, q_words.size() - start, n);
    endtask

    task automatic check_words(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < q_words.size()) begin
                check($sformatf("%s_w%0d", tag, i), q_words[base + i], exp_word(i));
                check($sformatf("%s_l%0d", tag, i), {31'b0, q_last[base + i]},
                      (i % 12 == 11) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int base, re0, done0, last0, bad0, exp_sum;

        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk50);
        #1;
        check("rst_re", {31'b0, read_enable}, 0);
        check("rst_valid", {31'b0, m_valid}, 0);
        check("rst_last", {31'b0, m_last}, 0);
        check("rst_done", {31'b0, frame_done}, 0);
        check("rst_csum", checksum, 0);
        check("rst_data", m_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk50);
        #1;

        // Two back-to-back frames at full rate.
        base = q_words.size(); re0 = n_re; done0 = n_done; last0 = re_at_last.size();
        control = 1'b1;
        wait_words("t1", 24, 0, 400);
        repeat (3) @(posedge clk50);
        #1;
        check_words("t1", base, 24);
        check("t1_done", n_done - done0, 2);
        if (re_at_last.size() >= last0 + 2) begin
            check("t1_re_f1", re_at_last[last0] - re0, 4);
            check("t1_re_f2", re_at_last[last0 + 1] - re0, 8);
        end else begin
            check("t1_nlast", re_at_last.size() - last0, 2);
        end
        exp_sum = 0;
        for (int i = 0; i < 12; i++) exp_sum += exp_word(i);
`ifdef PIXEL_CHECKSUM_EN
        check("t1_csum", checksum, exp_sum);
`else
        check("t1_csum", checksum, 0);
`endif
        control = 1'b0;
        @(posedge clk50);
        #1;
        check("t1_flush_valid", {31'b0, m_valid}, 0);
        repeat (5) @(posedge clk50);
        #1;

        // Throttled sink.
        base = q_words.size(); done0 = n_done; bad0 = n_re_bad;
        control = 1'b1;
        wait_words("t2", 12, 1, 600);
        repeat (2) @(posedge clk50);
        #1;
        check_words("t2", base, 12);
        check("t2_done", n_done - done0, 1);
        check("t2_re_bad", n_re_bad - bad0, 0);
        control = 1'b0;
        m_ready = 1'b0;
        repeat (5) @(posedge clk50);
        #1;

        // Abort mid-frame with words buffered, then restart.
        control = 1'b1;
        wait_words("t4a", 3, 0, 100);
        m_ready = 1'b0;
        repeat (10) @(posedge clk50);
        #1;
        check("t4_valid_before", {31'b0, m_valid}, 1);
        control = 1'b0;
        @(posedge clk50);
        #1;
        check("t4_valid_after", {31'b0, m_valid}, 0);
        check("t4_last_after", {31'b0, m_last}, 0);
        repeat (4) @(posedge clk50);
        #1;
        base = q_words.size();
        control = 1'b1;
        wait_words("t4b", 3, 0, 100);
        check_words("t4", base, 3);

        // Asynchronous reset while words are pending.
        m_ready = 1'b0;
        repeat (12) @(posedge clk50);
        #1;
        check("t5_valid_before", {31'b0, m_valid}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_valid", {31'b0, m_valid}, 0);
        check("t5_re", {31'b0, read_enable}, 0);
        check("t5_last", {31'b0, m_last}, 0);
        check("t5_data", m_data, 0);
        check("t5_done", {31'b0, frame_done}, 0);
        check("t5_csum", checksum, 0);
        #10 rst_n = 1'b1;
        base = q_words.size();
        wait_words("t5", 3, 0, 100);
        check_words("t5", base, 3);

        check("re_bad_total", n_re_bad, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
